// File: rtl/fetch_queue.sv
// Instruction fetch queue: issues word requests to imem and buffers {pc, word} for decode.
// Define FETCH_PREFETCH_EN for a 2-entry buffer (prefetch); otherwise a single entry.
module fetch_queue #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        inst_valid,
   output logic [31:0] inst,
   output logic [31:0] inst_pc,
   output logic [31:0] inst_pc_plus4,
   input  logic        inst_ready
);

`ifdef FETCH_PREFETCH_EN
   localparam int unsigned DEPTH = 2;
`else
   localparam int unsigned DEPTH = 1;
`endif
   localparam logic [1:0] DEPTH_C = 2'(DEPTH);
   localparam logic       LAST_PTR = 1'(DEPTH - 1);

   // Two physical slots; with DEPTH = 1 the pointers never leave slot 0.
   logic [31:0] buf_pc_q   [2];
   logic [31:0] buf_word_q [2];
   logic [31:0] fetch_pc_q, fetch_pc_d;
   logic        rd_ptr_q, rd_ptr_d;
   logic        wr_ptr_q, wr_ptr_d;
   logic [1:0]  count_q, count_d;
   logic [31:0] hold_pc_q, hold_word_q;
   logic        push, pop;

   function automatic logic ptr_inc(input logic p);
      return (p == LAST_PTR) ? 1'b0 : ~p;
   endfunction

   always_comb begin
      imem_req      = !reset && (count_q < DEPTH_C);
      imem_addr     = fetch_pc_q;
      inst_valid    = (count_q != 2'd0);
      // Empty head shows whatever was last presented.
      inst          = inst_valid ? buf_word_q[rd_ptr_q] : hold_word_q;
      inst_pc       = inst_valid ? buf_pc_q[rd_ptr_q]   : hold_pc_q;
      inst_pc_plus4 = inst_pc + 32'd4;
      push          = imem_req && imem_ack && !redirect;
      pop           = inst_valid && inst_ready && !redirect;
   end

   always_comb begin
      fetch_pc_d = fetch_pc_q;
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      count_d    = count_q;
      if (redirect) begin
         fetch_pc_d = {redirect_pc[31:2], 2'b00};
         rd_ptr_d   = 1'b0;
         wr_ptr_d   = 1'b0;
         count_d    = 2'd0;
      end else begin
         if (push) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
            wr_ptr_d   = ptr_inc(wr_ptr_q);
         end
         if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
         end
         count_d = count_q + {1'b0, push} - {1'b0, pop};
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fetch_pc_q  <= RESET_PC;
         rd_ptr_q    <= 1'b0;
         wr_ptr_q    <= 1'b0;
         count_q     <= 2'd0;
         hold_pc_q   <= 32'd0;
         hold_word_q <= 32'd0;
         for (int i = 0; i < 2; i++) begin
            buf_pc_q[i]   <= 32'd0;
            buf_word_q[i] <= 32'd0;
         end
      end else begin
         fetch_pc_q  <= fetch_pc_d;
         rd_ptr_q    <= rd_ptr_d;
         wr_ptr_q    <= wr_ptr_d;
         count_q     <= count_d;
         hold_pc_q   <= inst_pc;
         hold_word_q <= inst;
         if (push) begin
            buf_pc_q[wr_ptr_q]   <= fetch_pc_q;
            buf_word_q[wr_ptr_q] <= imem_rdata;
         end
      end
   end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: queue-based reference model with directed and random stimulus.
// Honours FETCH_PREFETCH_EN the same way as the design.
module tb_fetch_queue;

`ifdef FETCH_PREFETCH_EN
   localparam int DEPTH = 2;
`else
   localparam int DEPTH = 1;
`endif
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack = 1'b0;
   logic [31:0] imem_rdata = 32'd0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = 32'd0;
   logic        inst_valid;
   logic [31:0] inst, inst_pc, inst_pc_plus4;
   logic        inst_ready = 1'b0;

   fetch_queue #(.RESET_PC(RESET_PC)) dut (
      .clk          (clk),
      .reset        (reset),
      .imem_req     (imem_req),
      .imem_addr    (imem_addr),
      .imem_ack     (imem_ack),
      .imem_rdata   (imem_rdata),
      .redirect     (redirect),
      .redirect_pc  (redirect_pc),
      .inst_valid   (inst_valid),
      .inst         (inst),
      .inst_pc      (inst_pc),
      .inst_pc_plus4(inst_pc_plus4),
      .inst_ready   (inst_ready)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int valid_seen = 0;

   // Reference: a plain FIFO of fetched instructions plus the next fetch address.
   logic [31:0] m_pc;
   logic [31:0] q_pc[$];
   logic [31:0] q_word[$];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // One cycle: compare outputs, drive inputs, advance the model over the coming edge.
   task automatic step(input bit ack, input bit ready, input bit redir,
                       input logic [31:0] rpc, input bit rnd_word);
      logic [31:0] word;
      bit do_push, do_pop;
      @(negedge clk);
      check_eq("imem_req", imem_req, 32'(q_pc.size() < DEPTH));
      check_eq("imem_addr", imem_addr, m_pc);
      check_eq("inst_valid", inst_valid, 32'(q_pc.size() != 0));
      if (q_pc.size() != 0) begin
         valid_seen++;
         check_eq("inst", inst, q_word[0]);
         check_eq("inst_pc", inst_pc, q_pc[0]);
         check_eq("inst_pc_plus4", inst_pc_plus4, q_pc[0] + 32'd4);
      end
      word = rnd_word ? $urandom : (m_pc | 32'hA000_0000);
      imem_ack    = ack;
      imem_rdata  = word;
      inst_ready  = ready;
      redirect    = redir;
      redirect_pc = rpc;
      if (redir) begin
         q_pc.delete();
         q_word.delete();
         m_pc = rpc & 32'hFFFF_FFFC;
      end else begin
         do_push = ack && (q_pc.size() < DEPTH);
         do_pop  = ready && (q_pc.size() != 0);
         if (do_pop) begin
            void'(q_pc.pop_front());
            void'(q_word.pop_front());
         end
         if (do_push) begin
            q_pc.push_back(m_pc);
            q_word.push_back(word);
            m_pc = m_pc + 32'd4;
         end
      end
   endtask

   task automatic model_reset();
      q_pc.delete();
      q_word.delete();
      m_pc = RESET_PC;
   endtask

   initial begin
      model_reset();
      // Reset state
      repeat (2) @(negedge clk);
      check_eq("rst imem_req", imem_req, 0);
      check_eq("rst imem_addr", imem_addr, RESET_PC);
      check_eq("rst inst_valid", inst_valid, 0);
      check_eq("rst inst", inst, 0);
      check_eq("rst inst_pc", inst_pc, 0);
      check_eq("rst inst_pc_plus4", inst_pc_plus4, 4);
      reset = 1'b0;
      #1;
      check_eq("first req", imem_req, 1);
      check_eq("first addr", imem_addr, RESET_PC);

      // Streaming with zero-wait memory and an always-ready consumer
      valid_seen = 0;
      for (int i = 0; i < 8; i++) step(1, 1, 0, 0, 0);
      check_eq("stream valid cycles", valid_seen, (DEPTH == 2) ? 7 : 4);

      // Backpressure from a fresh start at 0
      step(0, 0, 1, 32'h0, 0);
      for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 0);
      check_eq("bp req low", imem_req, 0);
      check_eq("bp head pc", inst_pc, 32'h0);
      for (int i = 0; i < 6; i++) step(1, 1, 0, 0, 0);

      // Redirect while full with ack high
      for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0);
      step(1, 0, 1, 32'h40, 0);
      step(1, 1, 0, 0, 0);
      check_eq("redir valid", inst_valid, 0);
      check_eq("redir addr", imem_addr, 32'h40);
      step(0, 1, 0, 0, 0);
      check_eq("redir pc", inst_pc, 32'h40);
      check_eq("redir pc4", inst_pc_plus4, 32'h44);
      check_eq("redir word", inst, 32'hA000_0040);

      // Wait-state memory: request held for 4 cycles, one push
      step(0, 1, 1, 32'h100, 0);
      for (int i = 0; i < 3; i++) begin
         step(0, 1, 0, 0, 0);
         check_eq("ws req", imem_req, 1);
         check_eq("ws addr", imem_addr, 32'h100);
      end
      step(1, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      check_eq("ws pc", inst_pc, 32'h100);

      // Address wrap
      step(0, 1, 1, 32'hFFFF_FFFE, 0);
      step(1, 0, 0, 0, 0);
      check_eq("wrap addr0", imem_addr, 32'hFFFF_FFFC);
      step(1, 0, 0, 0, 0);
      check_eq("wrap addr1", imem_addr, 32'h0);
      check_eq("wrap pc", inst_pc, 32'hFFFF_FFFC);
      check_eq("wrap pc4", inst_pc_plus4, 32'h0);
      step(1, 0, 0, 0, 0);

      // Reset mid-fetch with the buffer full and ack high
      @(negedge clk);
      reset    = 1'b1;
      imem_ack = 1'b1;
      #1;
      check_eq("midrst req", imem_req, 0);
      check_eq("midrst valid", inst_valid, 0);
      @(posedge clk);
      #1;
      check_eq("midrst valid2", inst_valid, 0);
      check_eq("midrst req2", imem_req, 0);
      @(negedge clk);
      reset      = 1'b0;
      imem_ack   = 1'b0;
      inst_ready = 1'b0;
      redirect   = 1'b0;
      model_reset();
      #1;
      check_eq("restart req", imem_req, 1);
      check_eq("restart addr", imem_addr, RESET_PC);

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         step(($urandom % 3) != 0, ($urandom % 4) != 0, ($urandom % 16) == 0,
              $urandom, 1);
      end
      step(0, 0, 0, 0, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
